jtframe_prio_colmix: RTL and testbench

Parametrised colour mixer with run-time layer priority and a dual-port palette RAM. It sits between the tile/sprite layer generators and the video output of a core. Each pixel slot it picks the highest-priority opaque layer and fetches that layer's colour from an 8-bit palette in two sequenced byte reads. It also exposes a CPU read/write port to the palette and flags pixel-clock overruns.

---
 rtl/jtframe_prio_colmix.sv | 202 ++++++++++++++++++++
 tb/tb_jtframe_prio_colmix.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_prio_colmix.sv
// Priority colour mixer: picks the highest-priority opaque layer each pixel and
// fetches its colour from a dual-port byte palette with two sequenced reads.
module jtframe_prio_colmix #(
    parameter int LAYERS  = 3,
    parameter int LW      = 2,
    parameter int PXLW    = 6,
    parameter int BPP     = 3,
    parameter int CW      = 4,
    parameter     SIMFILE = "pal.bin"
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pxl_cen,
    input  logic                   LHBL,
    input  logic                   LVBL,
    input  logic [LAYERS*PXLW-1:0] pxl,
    input  logic [LAYERS*LW-1:0]   prio,
    input  logic [LAYERS-1:0]      gfx_en,
    input  logic                   pal_cs,
    input  logic                   cpu_wrn,
    input  logic [LW+PXLW:0]       cpu_addr,
    input  logic [7:0]             cpu_dout,
    output logic [7:0]             pal_dout,
    output logic [CW-1:0]          red,
    output logic [CW-1:0]          green,
    output logic [CW-1:0]          blue,
    output logic                   LHBL_dly,
    output logic                   LVBL_dly,
    output logic                   ovr
);
    localparam int AW  = 1 + LW + PXLW;
    localparam int NID = 1 << LW;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD_LO = 3'd1;
    localparam logic [2:0] ST_RD_HI = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic                unused_simfile;
    assign unused_simfile = ^SIMFILE;

    logic [2:0]          state_q, state_d;
    logic [LW+PXLW-1:0]  pal_a_q, pal_a_d;
    logic [CW-1:0]       stg_r_q, stg_r_d, stg_g_q, stg_g_d;
    logic [CW-1:0]       nr_q, nr_d, ng_q, ng_d, nb_q, nb_d;
    logic [CW-1:0]       red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic                hs_q, hs_d, vs_q, vs_d;
    logic                hdly_q, hdly_d, vdly_q, vdly_d;
    logic                ovr_q, ovr_d;
    logic                busy;

    logic [7:0]          mem [2**AW];
    logic [7:0]          vid_q;
    logic [7:0]          pal_dout_q;
    logic [AW-1:0]       vid_addr;

    // Layers are spread over the full id space so out-of-range ids read as transparent
    logic [PXLW-1:0]     lyr [NID];
    logic                en  [NID];

    always_comb begin
        for (int i = 0; i < NID; i++) begin
            lyr[i] = '0;
            en[i]  = 1'b0;
        end
        for (int i = 0; i < LAYERS; i++) begin
            lyr[i] = pxl[i*PXLW +: PXLW];
            en[i]  = gfx_en[i];
        end
    end

    logic [LW-1:0]       win_id, slot_id;
    logic [PXLW-1:0]     win_pxl;
    logic                found;

    always_comb begin
        win_id  = prio[(LAYERS-1)*LW +: LW];
        win_pxl = en[win_id] ? lyr[win_id] : '0;
        found   = 1'b0;
        slot_id = '0;
        for (int k = 0; k < LAYERS; k++) begin
            slot_id = prio[k*LW +: LW];
            if (!found && en[slot_id] && (lyr[slot_id][BPP-1:0] != '0)) begin
                found   = 1'b1;
                win_id  = slot_id;
                win_pxl = lyr[slot_id];
            end
        end
    end

    assign busy = (state_q == ST_RD_LO) || (state_q == ST_RD_HI) || (state_q == ST_WAIT);

    always_comb begin
        state_d = state_q;
        pal_a_d = pal_a_q;
        stg_r_d = stg_r_q;
        stg_g_d = stg_g_q;
        nr_d    = nr_q;
        ng_d    = ng_q;
        nb_d    = nb_q;
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        hdly_d  = hdly_q;
        vdly_d  = vdly_q;
        ovr_d   = ovr_q;
        if (pxl_cen) begin
            // A new pixel aborts any fetch in flight; the colour shown is the last committed one
            state_d = ST_RD_LO;
            pal_a_d = {win_id, win_pxl};
            ovr_d   = ovr_q | busy;
            hs_d    = LHBL;
            vs_d    = LVBL;
            hdly_d  = hs_q;
            vdly_d  = vs_q;
            if (hs_q && vs_q) begin
                red_d   = nr_q;
                green_d = ng_q;
                blue_d  = nb_q;
            end else begin
                red_d   = '0;
                green_d = '0;
                blue_d  = '0;
            end
        end else begin
            case (state_q)
                ST_RD_LO: state_d = ST_RD_HI;
                ST_RD_HI: begin
                    state_d = ST_WAIT;
                    stg_r_d = vid_q[CW-1:0];
                    stg_g_d = vid_q[4 +: CW];
                end
                ST_WAIT: begin
                    state_d = ST_DONE;
                    nr_d    = stg_r_q;
                    ng_d    = stg_g_q;
                    nb_d    = vid_q[CW-1:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pal_a_q <= '0;
            stg_r_q <= '0;
            stg_g_q <= '0;
            nr_q    <= '0;
            ng_q    <= '0;
            nb_q    <= '0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            hdly_q  <= 1'b0;
            vdly_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pal_a_q <= pal_a_d;
            stg_r_q <= stg_r_d;
            stg_g_q <= stg_g_d;
            nr_q    <= nr_d;
            ng_q    <= ng_d;
            nb_q    <= nb_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            hdly_q  <= hdly_d;
            vdly_q  <= vdly_d;
            ovr_q   <= ovr_d;
        end
    end

    assign vid_addr = {state_q == ST_RD_HI, pal_a_q};

    // Read-before-write: a same-edge CPU write is not seen by either read port
    always_ff @(posedge clk) begin
        if (pal_cs && !cpu_wrn) begin
            mem[cpu_addr] <= cpu_dout;
        end
        pal_dout_q <= mem[cpu_addr];
        vid_q      <= mem[vid_addr];
    end

    assign pal_dout = pal_dout_q;
    assign red      = red_q;
    assign green    = green_q;
    assign blue     = blue_q;
    assign LHBL_dly = hdly_q;
    assign LVBL_dly = vdly_q;
    assign ovr      = ovr_q;

endmodule

// File: tb/tb_jtframe_prio_colmix.sv
// Bench for jtframe_prio_colmix: table of pixel vectors checked through a
// scoreboard, plus hand-written overrun, reset and palette-port sequences.
module tb_jtframe_prio_colmix;
    logic        clk = 1'b0;
    logic        rst;
    logic        pxl_cen;
    logic        LHBL, LVBL;
    logic [17:0] pxl;
    logic [5:0]  prio;
    logic [2:0]  gfx_en;
    logic        pal_cs, cpu_wrn;
    logic [8:0]  cpu_addr;
    logic [7:0]  cpu_dout;
    logic [7:0]  pal_dout;
    logic [3:0]  red, green, blue;
    logic        LHBL_dly, LVBL_dly, ovr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0] l0, l1, l2;
        logic [5:0] pr;
        logic [2:0] en;
        logic       hb, vb;
        logic [7:0] exp_a;
    } vec_t;

    typedef struct {
        logic [3:0] r, g, b;
        logic       hb, vb;
    } exp_t;

    vec_t       vt [12];
    exp_t       sb [$];
    logic [7:0] pal_m [512];

    jtframe_prio_colmix #(
        .LAYERS(3), .LW(2), .PXLW(6), .BPP(3), .CW(4), .SIMFILE("pal.bin")
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pxl_cen  (pxl_cen),
        .LHBL     (LHBL),
        .LVBL     (LVBL),
        .pxl      (pxl),
        .prio     (prio),
        .gfx_en   (gfx_en),
        .pal_cs   (pal_cs),
        .cpu_wrn  (cpu_wrn),
        .cpu_addr (cpu_addr),
        .cpu_dout (cpu_dout),
        .pal_dout (pal_dout),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .LHBL_dly (LHBL_dly),
        .LVBL_dly (LVBL_dly),
        .ovr      (ovr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse();
        pxl_cen = 1'b1;
        step(1);
        pxl_cen = 1'b0;
    endtask

    task automatic cpu_write(input logic [8:0] a, input logic [7:0] d);
        pal_cs   = 1'b1;
        cpu_wrn  = 1'b0;
        cpu_addr = a;
        cpu_dout = d;
        step(1);
        pal_cs   = 1'b0;
        cpu_wrn  = 1'b1;
        pal_m[a] = d;
    endtask

    task automatic drive(input vec_t v);
        pxl    = {v.l2, v.l1, v.l0};
        prio   = v.pr;
        gfx_en = v.en;
        LHBL   = v.hb;
        LVBL   = v.vb;
    endtask

    function automatic exp_t mk_exp(input logic [7:0] a, input logic hb, input logic vb);
        exp_t       e;
        logic [7:0] lo, hi;
        lo   = pal_m[{1'b0, a}];
        hi   = pal_m[{1'b1, a}];
        e.hb = hb;
        e.vb = vb;
        if (hb && vb) begin
            e.r = lo[3:0];
            e.g = lo[7:4];
            e.b = hi[3:0];
        end else begin
            e.r = 4'h0;
            e.g = 4'h0;
            e.b = 4'h0;
        end
        return e;
    endfunction

    task automatic sb_check(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", nm);
        end else begin
            e = sb.pop_front();
            chk({nm, "_rgb"}, {red, green, blue}, {e.r, e.g, e.b});
            chk({nm, "_hdly"}, LHBL_dly, e.hb);
            chk({nm, "_vdly"}, LVBL_dly, e.vb);
        end
    endtask

    initial begin
        exp_t       ep, eo, en_new;
        logic [7:0] d;

        rst = 1'b1; pxl_cen = 1'b0; LHBL = 1'b0; LVBL = 1'b0;
        pxl = '0; prio = '0; gfx_en = '0;
        pal_cs = 1'b0; cpu_wrn = 1'b1; cpu_addr = '0; cpu_dout = '0;
        step(2);
        chk("reset_rgb", {red, green, blue}, 12'h000);
        chk("reset_dly", {LHBL_dly, LVBL_dly}, 2'b00);
        chk("reset_ovr", ovr, 1'b0);
        rst = 1'b0;
        step(1);

        for (int a = 0; a < 512; a++) begin
            d = 8'((a * 37 + 11) & 255);
            if (a == 'h005) d = 8'hA3;
            if (a == 'h105) d = 8'h07;
            cpu_write(9'(a), d);
        end

        //       l0     l1     l2     prio {s2,s1,s0}       en      hb    vb    pal_a
        vt[0]  = '{6'h05, 6'h09, 6'h00, {2'd2, 2'd1, 2'd0}, 3'b111, 1'b1, 1'b1, 8'h05};
        vt[1]  = '{6'h05, 6'h09, 6'h00, {2'd2, 2'd0, 2'd1}, 3'b111, 1'b1, 1'b1, 8'h49};
        vt[2]  = '{6'h10, 6'h18, 6'h08, {2'd2, 2'd1, 2'd0}, 3'b111, 1'b1, 1'b1, 8'h88};
        vt[3]  = '{6'h10, 6'h18, 6'h08, {2'd2, 2'd1, 2'd0}, 3'b011, 1'b1, 1'b1, 8'h80};
        vt[4]  = '{6'h05, 6'h09, 6'h0B, {2'd2, 2'd1, 2'd0}, 3'b110, 1'b1, 1'b1, 8'h49};
        vt[5]  = '{6'h05, 6'h09, 6'h0B, {2'd0, 2'd1, 2'd2}, 3'b111, 1'b1, 1'b1, 8'h8B};
        vt[6]  = '{6'h3F, 6'h21, 6'h12, {2'd1, 2'd2, 2'd0}, 3'b111, 1'b1, 1'b1, 8'h3F};
        vt[7]  = '{6'h08, 6'h21, 6'h12, {2'd1, 2'd2, 2'd0}, 3'b111, 1'b1, 1'b1, 8'h92};
        vt[8]  = '{6'h28, 6'h10, 6'h30, {2'd0, 2'd2, 2'd1}, 3'b111, 1'b1, 1'b1, 8'h28};
        vt[9]  = '{6'h05, 6'h09, 6'h00, {2'd2, 2'd1, 2'd0}, 3'b111, 1'b0, 1'b1, 8'h05};
        vt[10] = '{6'h05, 6'h09, 6'h00, {2'd2, 2'd0, 2'd1}, 3'b111, 1'b1, 1'b0, 8'h49};
        vt[11] = '{6'h3F, 6'h21, 6'h12, {2'd1, 2'd2, 2'd0}, 3'b000, 1'b1, 1'b1, 8'h40};

        sb.push_back('{4'h0, 4'h0, 4'h0, 1'b0, 1'b0});
        for (int i = 0; i < 12; i++) begin
            drive(vt[i]);
            pulse();
            sb_check($sformatf("vec%0d", i));
            sb.push_back(mk_exp(vt[i].exp_a, vt[i].hb, vt[i].vb));
            step(3);
        end
        pulse();
        sb_check("flush");
        step(3);

        // Overrun: second pxl_cen two clocks after the first
        ep = mk_exp(8'h05, 1'b1, 1'b1);
        drive(vt[0]);
        pulse();
        step(3);
        drive(vt[5]);
        pulse();
        chk("ovr_before", ovr, 1'b0);
        chk("rgb_before", {red, green, blue}, {ep.r, ep.g, ep.b});
        step(1);
        pulse();
        chk("ovr_set", ovr, 1'b1);
        chk("rgb_hold", {red, green, blue}, {ep.r, ep.g, ep.b});
        step(3);
        pulse();
        chk("ovr_sticky", ovr, 1'b1);

        rst = 1'b1;
        #1;
        chk("rst_ovr", ovr, 1'b0);
        chk("rst_rgb", {red, green, blue}, 12'h000);
        chk("rst_dly", {LHBL_dly, LVBL_dly}, 2'b00);
        step(2);
        rst = 1'b0;
        step(1);

        cpu_write(9'h010, 8'h5C);
        cpu_addr = 9'h010;
        step(1);
        chk("cpu_rd_010", pal_dout, 8'h5C);
        cpu_addr = 9'h105;
        step(1);
        chk("cpu_rd_105", pal_dout, pal_m[9'h105]);

        // CPU write to the byte the video port reads on the same edge
        drive(vt[0]);
        pulse();
        step(3);
        pulse();
        step(3);
        eo = mk_exp(8'h05, 1'b1, 1'b1);
        pulse();
        pal_cs = 1'b1; cpu_wrn = 1'b0; cpu_addr = 9'h005; cpu_dout = 8'h6E;
        step(1);
        pal_cs = 1'b0; cpu_wrn = 1'b1;
        pal_m[9'h005] = 8'h6E;
        en_new = mk_exp(8'h05, 1'b1, 1'b1);
        step(2);
        pulse();
        chk("coll_old", {red, green, blue}, {eo.r, eo.g, eo.b});
        step(3);
        pulse();
        chk("coll_new", {red, green, blue}, {en_new.r, en_new.g, en_new.b});
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
